// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the
// instruction-fetch port (if_*) and the load/store port (dm_*).
//
// One request is served at a time. In IDLE the winner's command is latched
// into the mem_* registers and held for MEM_LAT cycles (ACCESS). On the last
// access cycle mem_rdata is captured into the owner's rdata register (loads
// and fetches only), and the owner's ready pulses for exactly one cycle (RESP).
//
// Handshake: if_req/dm_req are levels held with a stable command until the
// matching *_ready pulse. In the cycle after ready the requester either drops
// req or presents a new command; a req seen in the following IDLE cycle is a
// new request. Requests are sampled only in IDLE, so anything that changes
// during ACCESS or RESP is ignored. *_rdata is valid while *_ready=1.
//
// Arbitration: data wins unless both requests are high and the data grant
// streak has reached STARVE_LIM, in which case fetch wins.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address
//   if_rdata/if_ready   fetched word and completion pulse
//   dm_req/we/size/addr/wdata  data request and command
//   dm_rdata/dm_ready   load data and completion pulse (loads and stores)
//   mem_en/we/size/addr/wdata  registered memory command
//   mem_rdata           memory read data, valid in the last ACCESS cycle
//   busy                1 in ACCESS or RESP
//   owner               current/last grant: 0 fetch, 1 data
//   state_dbg           FSM state: 0 IDLE, 1 ACCESS, 2 RESP
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  localparam logic [2:0] SLIM   = 3'(STARVE_LIM);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [2:0] streak;

  logic any_req;
  logic fetch_win;
  logic latch_cmd;
  logic access_done;
  logic resp_end;

  assign any_req   = if_req | dm_req;
  assign fetch_win = if_req & (~dm_req | (streak == SLIM));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req)    state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == 3'd0) state_nxt = ST_RESP;
      ST_RESP:                   state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes driving the registered datapath
  always_comb begin
    latch_cmd   = 1'b0;
    access_done = 1'b0;
    resp_end    = 1'b0;
    state_dbg   = state;
    case (state)
      ST_IDLE:   latch_cmd   = any_req;
      ST_ACCESS: access_done = (cnt == 3'd0);
      ST_RESP:   resp_end    = 1'b1;
      default:   ;
    endcase
  end

  // Registered command, response and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 3'd0;
      streak    <= 3'd0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
    end else begin
      if (latch_cmd) begin
        owner  <= ~fetch_win;
        busy   <= 1'b1;
        mem_en <= 1'b1;
        cnt    <= LAT_M1;
        if (fetch_win) begin
          mem_we    <= 1'b0;
          mem_size  <= 2'b10;
          mem_addr  <= if_addr;
          mem_wdata <= 32'd0;
          streak    <= 3'd0;
        end else begin
          mem_we    <= dm_we;
          mem_size  <= dm_size;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          // Only grants that beat a waiting fetch count towards starvation.
          if (!if_req)             streak <= 3'd0;
          else if (streak != SLIM) streak <= streak + 3'd1;
        end
      end

      if (state == ST_ACCESS && cnt != 3'd0) cnt <= cnt - 3'd1;

      if (access_done) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (owner) begin
          dm_ready <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end

      if (resp_end) begin
        if_ready <= 1'b0;
        dm_ready <= 1'b0;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_LIM = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [1:0]  dm_size;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, busy, owner;
  logic [1:0]  mem_size, state_dbg;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .state_dbg(state_dbg)
  );

  // Memory model: read data is only valid in the last cycle of an access.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0051_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  int acc_cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst)        acc_cyc <= 0;
    else if (mem_en) acc_cyc <= acc_cyc + 1;
    else             acc_cyc <= 0;
  end

  always_comb begin
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_en && !mem_we && acc_cyc == MEM_LAT - 1) mem_rdata = mem_data(mem_addr);
  end

  // Driver tasks (called at a falling edge)
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'd0; dm_wdata = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic dm_cmd(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    dm_req = 1'b1; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    dm_cmd(1'b0, 2'b10, 32'h200, 32'h0);
    tick();
    tick();
    n_vec++;
    if ({if_ready, dm_ready, mem_en, mem_we, busy, owner} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {if_ready, dm_ready, mem_en, mem_we, busy, owner});
    end
    n_vec++;
    if ({if_rdata, dm_rdata, mem_addr, mem_wdata, mem_size} !== 130'd0) begin
      n_err++;
      $display("FAIL reset_data: if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h mem_size=%b expected all 0",
               if_rdata, dm_rdata, mem_addr, mem_wdata, mem_size);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({owner, mem_en, busy} !== 3'b111 || mem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL reset_first_grant: owner=%b mem_en=%b busy=%b mem_addr=%h expected 1 1 1 00000200",
               owner, mem_en, busy, mem_addr);
    end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;             // cycle 1 (IDLE)
    tick();                                      // cycle 2
    n_vec++;
    if ({mem_en, mem_we, mem_size, owner} !== 5'b10100 || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL fetch_c2: en=%b we=%b size=%b owner=%b addr=%h expected 1 0 10 0 00000010",
               mem_en, mem_we, mem_size, owner, mem_addr);
    end
    tick();                                      // cycle 3
    n_vec++;
    if ({mem_en, mem_size, if_ready} !== 4'b1100 || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL fetch_c3: en=%b size=%b if_ready=%b addr=%h expected 1 10 0 00000010",
               mem_en, mem_size, if_ready, mem_addr);
    end
    tick();                                      // cycle 4
    n_vec++;
    if ({if_ready, dm_ready, mem_en} !== 3'b100 || if_rdata !== 32'h0051_0093) begin
      n_err++;
      $display("FAIL fetch_c4: if_ready=%b dm_ready=%b en=%b if_rdata=%h expected 1 0 0 00510093",
               if_ready, dm_ready, mem_en, if_rdata);
    end
    if_req = 1'b0;
    tick();                                      // cycle 5
    n_vec++;
    if ({if_ready, busy, state_dbg} !== 4'b0000) begin
      n_err++;
      $display("FAIL fetch_c5: if_ready=%b busy=%b state=%0d expected 0 0 0",
               if_ready, busy, state_dbg);
    end
  endtask

  task automatic test_store();
    int en_cnt, ok_cnt, rdy_cnt, if_cnt;
    bit got;
    do_reset();
    dm_cmd(1'b0, 2'b10, 32'h300, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (dm_ready) got = 1'b1;
    end
    n_vec++;
    if (!got || dm_rdata !== mem_data(32'h300)) begin
      n_err++;
      $display("FAIL store_preload: ready_seen=%b dm_rdata=%h expected 1 %h",
               got, dm_rdata, mem_data(32'h300));
    end
    dm_req = 1'b0;
    tick();
    dm_cmd(1'b1, 2'b00, 32'h103, 32'hAB);
    en_cnt = 0; ok_cnt = 0; rdy_cnt = 0; if_cnt = 0;
    for (int i = 0; i < MEM_LAT + 3; i++) begin
      tick();
      if (mem_en) en_cnt++;
      if (mem_en && mem_we && mem_size == 2'b00 && mem_addr == 32'h103 && mem_wdata == 32'hAB)
        ok_cnt++;
      if (if_ready) if_cnt++;
      if (dm_ready) begin
        rdy_cnt++;
        dm_req = 1'b0;
      end
    end
    n_vec++;
    if (en_cnt != MEM_LAT || ok_cnt != MEM_LAT) begin
      n_err++;
      $display("FAIL store_cmd: en_cycles=%0d good_cmd_cycles=%0d expected %0d",
               en_cnt, ok_cnt, MEM_LAT);
    end
    n_vec++;
    if (rdy_cnt != 1 || if_cnt != 0) begin
      n_err++;
      $display("FAIL store_ready: dm_ready_pulses=%0d if_ready_pulses=%0d expected 1 0",
               rdy_cnt, if_cnt);
    end
    n_vec++;
    if (dm_rdata !== mem_data(32'h300) || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL store_rdata_kept: dm_rdata=%h mem_we=%b expected %h 0",
               dm_rdata, mem_we, mem_data(32'h300));
    end
  endtask

  task automatic test_contention();
    logic exp_q[$];
    logic got_q[$];
    int both, bad_rd;
    do_reset();
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    if_req = 1'b1; if_addr = 32'h1000;
    dm_cmd(1'b0, 2'b10, 32'h2000, 32'h0);
    both = 0; bad_rd = 0;
    for (int i = 0; i < 8 * (MEM_LAT + 2) + 10 && got_q.size() < 8; i++) begin
      tick();
      if (if_ready && dm_ready) both++;
      if (dm_ready) begin
        got_q.push_back(1'b1);
        if (dm_rdata !== mem_data(32'h2000)) bad_rd++;
      end else if (if_ready) begin
        got_q.push_back(1'b0);
        if (if_rdata !== mem_data(32'h1000)) bad_rd++;
      end
    end
    n_vec++;
    if (got_q.size() != 8 || both != 0 || bad_rd != 0) begin
      n_err++;
      $display("FAIL contention_count: grants=%0d both_ready=%0d bad_rdata=%0d expected 8 0 0",
               got_q.size(), both, bad_rd);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL contention_order[%0d]: got owner %b expected %b", i, got_q[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_access();
    int rdy_seen, n;
    bit got;
    do_reset();
    dm_cmd(1'b0, 2'b10, 32'h400, 32'h0);
    tick();                       // first ACCESS cycle
    @(posedge clk);               // second ACCESS cycle begins
    #2 rst = 1'b0;
    dm_req = 1'b0;
    #1;
    n_vec++;
    if ({mem_en, busy, state_dbg} !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_async: mem_en=%b busy=%b state=%0d expected 0 0 0",
               mem_en, busy, state_dbg);
    end
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dm_ready || if_ready) rdy_seen++;
    end
    n_vec++;
    if (rdy_seen != 0) begin
      n_err++;
      $display("FAIL midreset_no_ready: ready_cycles=%0d expected 0", rdy_seen);
    end
    rst = 1'b1;
    dm_cmd(1'b0, 2'b10, 32'h400, 32'h0);
    got = 1'b0; n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      n++;
      if (dm_ready) got = 1'b1;
    end
    n_vec++;
    if (!got || n != MEM_LAT + 1 || dm_rdata !== mem_data(32'h400)) begin
      n_err++;
      $display("FAIL midreset_reissue: ready_seen=%b latency=%0d dm_rdata=%h expected 1 %0d %h",
               got, n, dm_rdata, MEM_LAT + 1, mem_data(32'h400));
    end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n1, n2, bad_addr;
    bit got;
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    got = 1'b0; n1 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      n1++;
      if (if_ready) got = 1'b1;
    end
    n_vec++;
    if (!got || if_rdata !== mem_data(32'h20)) begin
      n_err++;
      $display("FAIL b2b_first: ready_seen=%b if_rdata=%h expected 1 %h",
               got, if_rdata, mem_data(32'h20));
    end
    if_addr = 32'h14;             // new command presented in the RESP cycle
    got = 1'b0; n2 = 0; bad_addr = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      n2++;
      if (mem_en && mem_addr !== 32'h14) bad_addr++;
      if (if_ready) got = 1'b1;
    end
    n_vec++;
    if (!got || n2 != MEM_LAT + 2 || bad_addr != 0) begin
      n_err++;
      $display("FAIL b2b_spacing: ready_seen=%b spacing=%0d bad_addr_cycles=%0d expected 1 %0d 0",
               got, n2, bad_addr, MEM_LAT + 2);
    end
    n_vec++;
    if (if_rdata !== mem_data(32'h14)) begin
      n_err++;
      $display("FAIL b2b_rdata: got %h expected %h", if_rdata, mem_data(32'h14));
    end
    if_req = 1'b0;
    tick();
  endtask

  // Randomized traffic against a transaction-timeline reference model.
  task automatic test_random();
    int pos, m_streak;
    logic m_owner, m_we, fw;
    logic [1:0] m_size;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
    logic exp_en, exp_resp;
    logic [5:0] exp_v, act_v;
    bit if_act, dm_act;
    do_reset();
    pos = -1; m_streak = 0; m_owner = 1'b0; m_we = 1'b0; m_size = 2'b00;
    m_addr = 32'd0; m_wdata = 32'd0; m_if_rd = 32'd0; m_dm_rd = 32'd0;
    if_act = 1'b0; dm_act = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      exp_en   = (pos >= 1 && pos <= MEM_LAT);
      exp_resp = (pos == MEM_LAT + 1);
      exp_v = {exp_en, pos >= 1, m_owner, exp_resp && !m_owner, exp_resp && m_owner, exp_en && m_we};
      act_v = {mem_en, busy, owner, if_ready, dm_ready, mem_we};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL rand_ctrl @%0d: {en,busy,owner,if_rdy,dm_rdy,we} got %b expected %b",
                 k, act_v, exp_v);
      end
      n_vec++;
      if (if_rdata !== m_if_rd || dm_rdata !== m_dm_rd) begin
        n_err++;
        $display("FAIL rand_rdata @%0d: if=%h dm=%h expected if=%h dm=%h",
                 k, if_rdata, dm_rdata, m_if_rd, m_dm_rd);
      end
      if (exp_en) begin
        n_vec++;
        if (mem_addr !== m_addr || mem_size !== m_size || (m_we && mem_wdata !== m_wdata)) begin
          n_err++;
          $display("FAIL rand_cmd @%0d: addr=%h size=%b wdata=%h expected %h %b %h",
                   k, mem_addr, mem_size, mem_wdata, m_addr, m_size, m_wdata);
        end
      end

      // Requesters: hold until ready, then drop or issue a new command.
      if ((exp_resp && !m_owner) || (!if_act && $urandom_range(0, 2) == 0)) begin
        if_act = (exp_resp && !m_owner) ? ($urandom_range(0, 1) == 1) : 1'b1;
        if_addr = $urandom;
      end
      if ((exp_resp && m_owner) || (!dm_act && $urandom_range(0, 2) == 0)) begin
        dm_act = (exp_resp && m_owner) ? ($urandom_range(0, 1) == 1) : 1'b1;
        dm_we = $urandom_range(0, 1) == 1;
        dm_size = 2'($urandom_range(0, 2));
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      if_req = if_act;
      dm_req = dm_act;

      // Model the effect of the coming clock edge.
      if (pos == -1) begin
        if (if_req || dm_req) begin
          fw = if_req && (!dm_req || m_streak == STARVE_LIM);
          m_owner = !fw;
          if (fw) begin
            m_we = 1'b0; m_size = 2'b10; m_addr = if_addr; m_wdata = 32'd0;
            m_streak = 0;
          end else begin
            m_we = dm_we; m_size = dm_size; m_addr = dm_addr; m_wdata = dm_wdata;
            if (!if_req) m_streak = 0;
            else if (m_streak < STARVE_LIM) m_streak++;
          end
          pos = 1;
        end
      end else if (pos <= MEM_LAT) begin
        if (pos == MEM_LAT && !m_we) begin
          if (m_owner) m_dm_rd = mem_data(m_addr);
          else         m_if_rd = mem_data(m_addr);
        end
        pos++;
      end else begin
        pos = -1;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
